// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Adds two W-bit operands (W = 4*NIB) through a single shared 4-bit adder
// slice, one nibble per clock, least-significant nibble first. Operands are
// latched when start is accepted in IDLE, and the slice carry is registered
// between nibbles. The assembled sum and final carry-out are held until the
// next accepted start.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  operation request, sampled only in IDLE
//   a      in   W  operand A, latched on accepted start
//   b      in   W  operand B, latched on accepted start
//   ci     in   1  carry-in, latched on accepted start
//   sub    in   1  subtract request (only honoured with NIBBLE_SERIAL_SUB_EN)
//   s      out  W  sum register
//   co     out  1  final carry-out (no-borrow flag when subtracting)
//   busy   out  1  high in RUN and DONE
//   done   out  1  one-cycle completion pulse
//
// Build option:
//   NIBBLE_SERIAL_SUB_EN  when defined, sub=1 computes a - b (b inverted,
//                         carry-in forced to 1, ci ignored). When undefined,
//                         sub is ignored and no subtract logic exists.
//
// FSM states:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for start; s/co hold the last result
//   RUN     | one nibble per cycle through the adder slice, cnt = slice index
//   DONE    | done pulse, result final; returns to IDLE unconditionally

module nibble_serial_adder_ctrl #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic [4*NIB-1:0] s,
  output logic             co,
  output logic             busy,
  output logic             done
);

  localparam int W  = 4 * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;     // holds the effective (possibly inverted) B
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    s_q, s_d;
  logic            co_q, co_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    b_eff;
  logic            cin_eff;

`ifdef NIBBLE_SERIAL_SUB_EN
  // Two's-complement subtraction: a + ~b + 1.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : ci;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign cin_eff    = ci;
`endif

  logic [3:0] nib_a, nib_b;
  logic [4:0] slice_sum;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    co_d      = co_q;
    nib_a     = 4'd0;
    nib_b     = 4'd0;
    slice_sum = 5'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = cin_eff;
          s_d     = '0;
          co_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Slice select written as a decoded mux so the index never walks
        // past the operand, whatever width cnt has.
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) begin
            nib_a = a_q[4*i +: 4];
            nib_b = b_q[4*i +: 4];
          end
        end
        slice_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, carry_q};
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) begin
            s_d[4*i +: 4] = slice_sum[3:0];
          end
        end
        carry_d = slice_sum[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          co_d    = slice_sum[4];
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered versions of the next state.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s    = s_q;
  assign co   = co_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl (NIB = 4).
// A posedge process decides, from the handshake rules alone, when an
// operation is accepted and pushes the arithmetic result onto a queue.
// A negedge monitor checks busy/done against the predicted timeline and
// pops/compares the result whenever done is seen.

module tb_nibble_serial_adder_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ci    = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] s;
  logic         co;
  logic         busy;
  logic         done;

  nibble_serial_adder_ctrl #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .sub   (sub),
    .s     (s),
    .co    (co),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
  } exp_t;

  exp_t q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;   // number of rising edges seen so far
  bit   op_valid = 1'b0;
  int   acc      = 0;   // edge index that accepted the latest operation

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mci, input logic msub);
    exp_t    e;
    longint  total;
`ifdef NIBBLE_SERIAL_SUB_EN
    if (msub) begin
      e.s  = ma - mb;
      e.co = (ma >= mb);
      return e;
    end
`endif
    total = longint'(ma) + longint'(mb) + longint'(mci);
    e.s   = total[W-1:0];
    e.co  = total[W];
    return e;
  endfunction

  // Acceptance model: start counts only when the block is idle, i.e. no
  // operation yet, or at least NIB+2 edges after the previous acceptance.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      op_valid = 1'b0;
      q.delete();
    end else if (start && (!op_valid || cyc >= acc + NIB + 2)) begin
      acc      = cyc;
      op_valid = 1'b1;
      q.push_back(model(a, b, ci, sub));
    end
  end

  always @(negedge clk) begin
    bit   eb, ed;
    exp_t e;
    eb = rst_n && op_valid && (cyc <= acc + NIB);
    ed = rst_n && op_valid && (cyc == acc + NIB);
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, eb);
    end
    checks++;
    if (done !== ed) begin
      errors++;
      $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, ed);
    end
    if (done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d s=%h co=%b", cyc, s, co);
      end else begin
        e = q.pop_front();
        if (s !== e.s || co !== e.co) begin
          errors++;
          $display("FAIL result cyc=%0d got s=%h co=%b want s=%h co=%b",
                   cyc, s, co, e.s, e.co);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout cyc=%0d busy=%b want 0", cyc, busy);
    end
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                    input logic tci, input logic tsub);
    wait_idle();
    a     = ta;
    b     = tb_;
    ci    = tci;
    sub   = tsub;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [W-1:0] got,
                           input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("reset_s", s, '0);
    check_val("reset_co", {{(W-1){1'b0}}, co}, '0);

    op(16'h1234, 16'h4321, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op(16'h000F, 16'h0000, 1'b1, 1'b0);

    // start held high, a changed during RUN: first op uses original a,
    // the second is accepted NIB+2 edges later with the new a.
    wait_idle();
    a = 16'hA5A5; b = 16'h1111; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h0F0F;
    repeat (NIB + 2) @(negedge clk);
    start = 1'b0;

    // Reset during RUN after slice 1 has been processed.
    op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_s", s, '0);
    check_val("abort_co", {{(W-1){1'b0}}, co}, '0);
    check_val("abort_busy", {{(W-1){1'b0}}, busy}, '0);
    check_val("abort_done", {{(W-1){1'b0}}, done}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(16'h00FF, 16'h0001, 1'b0, 1'b0);

    op(16'h0005, 16'h0007, 1'b0, 1'b1);

    for (int i = 0; i < 50; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d want=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle sequencer that adds wide operands through one shared 4-bit full-adder slice, one nibble per clock, least-significant nibble first. It sits in front of the 4-bit adder datapath: it latches wide operands and steps the slice index, feeding each nibble and the registered carry to the adder. It assembles the sum and final carry-out and signals completion with a start/busy/done handshake.

## Interface
Parameters:
- NIB, default 4: number of 4-bit slices; operand width W = 4*NIB; legal range NIB >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  W  operand A; latched on accepted start.
- b  in  W  operand B; latched on accepted start.
- ci  in  1  carry-in; latched on accepted start.
- sub  in  1  subtract request; latched on accepted start. Function depends on SUB_EN.
- s  out  W  sum register; reset value 0.
- co  out  1  final carry-out; reset value 0.
- busy  out  1  high in RUN and DONE; reset value 0.
- done  out  1  one-cycle completion pulse; reset value 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1:
  - Latch a, b, ci and sub.
  - Clear s and co to 0; set the slice counter cnt to 0.
  - Load the carry register with the effective carry-in.
  - Go to RUN.
- IDLE, start=0: hold; s and co keep the last result.
- RUN, each cycle:
  - {c, sum} = a_r[4*cnt+:4] + b_eff[4*cnt+:4] + carry (5-bit result).
  - Write s[4*cnt+:4] = sum; carry <= c; cnt <= cnt + 1.
  - When cnt == NIB-1: also write co = c and go to DONE.
- DONE: done=1 for this one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; holding it high never restarts or corrupts an operation.
- Result is exactly (a + b_eff + cin_eff) mod 2^W; co is bit W of that sum.
- NIB=1: RUN lasts exactly one cycle.
- Reset asserted mid-operation: immediately go to IDLE and clear s, co, busy, done and internal registers. No done pulse is produced for the aborted operation.

## Timing
- Edge E0 samples start in IDLE: busy rises after E0.
- Edges E1..E_NIB process slices 0..NIB-1. Slice k of s becomes valid after edge E(k+1).
- done is high from E_NIB to E_NIB+1. busy falls at E_NIB+1.
- Latency: done rises NIB clock edges after the accepting edge. Throughput: one operation per NIB+2 cycles with start held high.
- s and co are stable and final while done=1, and remain unchanged until the next accepted start.

## Configuration
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined: sub=1 selects subtraction.
  - b_eff = ~b and cin_eff = 1; ci is ignored.
  - s = a - b mod 2^W; co = 1 means no borrow (a >= b unsigned).
  - sub=0 behaves as addition.
- Undefined: sub is accepted but ignored.
  - b_eff = b and cin_eff = ci always.
  - No subtract logic is synthesized.

## Test plan
- Reset: rst_n=0 then release -> s=0, co=0, busy=0, done=0; no activity without start.
- NIB=4, a=16'h1234, b=16'h4321, ci=0, start for one cycle -> s=16'h5555, co=0; done exactly 4 edges after the accepting edge; busy high for 5 cycles.
- Full carry ripple: a=16'hFFFF, b=16'h0001, ci=0 -> s=16'h0000, co=1. Also a=16'h000F, b=16'h0000, ci=1 -> s=16'h0010, co=0.
- start held high with a changed during RUN -> result reflects the first operands only. The next operation is accepted on the first IDLE cycle after done, and done pulses again NIB+2 cycles after the first.
- rst_n pulsed low during RUN (after slice 1) -> all outputs 0 immediately, no done. A subsequent start with a=16'h00FF, b=16'h0001 gives s=16'h0100, co=0.
- NIBBLE_SERIAL_SUB_EN defined, a=16'h0005, b=16'h0007, sub=1 -> s=16'hFFFE, co=0. Then 50 random {ci, a, b} operations with sub=0 compared against the expression a+b+ci.
